core_sequencer: RTL and testbench

Multi-cycle phase controller for the 16-bit core. It steps the datapath through fetch, decode, execute, memory and writeback, and emits one-cycle register-write enables for each phase. It shares the single memory port between instruction fetch and data access with a req/ack handshake. It sits between the combinational instruction decoder (halt, memory-write, register-write, flag-write and PC-load decisions) and the datapath registers (PC, IR, DR, MDR, register file, flags).

---
 rtl/core_pkg.sv | 27 ++
 rtl/core_sequencer_if.sv | 28 ++
 rtl/core_sequencer.sv | 175 +++++++++++++++++
 tb/tb_core_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types for the core sequencer.
//   state_t  - sequencer state encoding
//   PH_*     - bit positions of the one-hot phase vector
//   PHASE_W  - width of the phase vector
//   ICNT_W   - width of the retired-instruction counter
package core_pkg;

  localparam int unsigned PHASE_W = 5;
  localparam int unsigned ICNT_W  = 16;

  localparam int unsigned PH_FETCH  = 0;
  localparam int unsigned PH_DECODE = 1;
  localparam int unsigned PH_EXEC   = 2;
  localparam int unsigned PH_MEM    = 3;
  localparam int unsigned PH_WB     = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALTED
  } state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: shared memory-port handshake between the sequencer and memory.
//   mem_req      - access request (sequencer -> memory)
//   mem_we       - request is a store
//   mem_sel_data - address mux: 0 = PC (fetch), 1 = data address
//   mem_ack      - memory completes the current request this cycle
// Modports: master (sequencer side), slave (memory side).
interface core_sequencer_if;

  logic mem_req;
  logic mem_we;
  logic mem_sel_data;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_sel_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_sel_data,
    output mem_ack
  );

endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/memory/writeback phase
// controller for the 16-bit core, sharing one memory port between fetch and
// data access via a req/ack handshake.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start, step, stop        - run control pulses
//   dec_*                    - decoder decisions for the instruction in IR
//   bus (master)             - memory handshake: mem_req/mem_we/mem_sel_data/mem_ack
//   ir_we ... pc_load        - single-cycle datapath write strobes
//   phase                    - one-hot {WB,MEM,EXEC,DECODE,FETCH}
//   busy, halted             - run status
//   instr_cnt                - retired-instruction count (CORE_SEQ_ICOUNT_EN only)
// Strobes and status are decoded combinationally from the state register, so
// an asynchronous reset drops mem_req immediately.
// Build option: define CORE_SEQ_ICOUNT_EN to include the instr_cnt counter/port.
module core_sequencer
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic                stop,
  input  logic                dec_halt,
  input  logic                dec_mem_rd,
  input  logic                dec_mem_wr,
  input  logic                dec_reg_we,
  input  logic                dec_flag_we,
  input  logic                dec_pc_load,
  core_sequencer_if.master    bus,
  output logic                ir_we,
  output logic                pc_inc,
  output logic                dr_we,
  output logic                mdr_we,
  output logic                flag_we,
  output logic                rf_we,
  output logic                pc_load,
  output logic [PHASE_W-1:0]  phase,
  output logic                busy,
  output logic                halted
`ifdef CORE_SEQ_ICOUNT_EN
  ,
  output logic [ICNT_W-1:0]   instr_cnt
`endif
);

  state_t state, state_d;
  logic   step_mode, step_mode_d;
  logic   stop_pend, stop_pend_d;
  logic   req, we, sel_data;

  assign bus.mem_req      = req;
  assign bus.mem_we       = we;
  assign bus.mem_sel_data = sel_data;

  // State and run-control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step_mode <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_d;
      step_mode <= step_mode_d;
      stop_pend <= stop_pend_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d     = state;
    step_mode_d = step_mode;
    stop_pend_d = stop_pend;
    req         = 1'b0;
    we          = 1'b0;
    sel_data    = 1'b0;
    ir_we       = 1'b0;
    pc_inc      = 1'b0;
    dr_we       = 1'b0;
    mdr_we      = 1'b0;
    flag_we     = 1'b0;
    rf_we       = 1'b0;
    pc_load     = 1'b0;
    phase       = '0;
    busy        = 1'b0;
    halted      = 1'b0;

    unique case (state)
      IDLE: begin
        stop_pend_d = 1'b0;
        // A simultaneous stop vetoes both start and step
        if (!stop) begin
          if (start) begin
            state_d     = FETCH;
            step_mode_d = 1'b0;
          end else if (step) begin
            state_d     = FETCH;
            step_mode_d = 1'b1;
          end
        end
      end

      FETCH: begin
        busy            = 1'b1;
        phase[PH_FETCH] = 1'b1;
        req             = 1'b1;
        if (bus.mem_ack) begin
          ir_we   = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        busy             = 1'b1;
        phase[PH_DECODE] = 1'b1;
        state_d          = dec_halt ? HALTED : EXEC;
      end

      EXEC: begin
        busy           = 1'b1;
        phase[PH_EXEC] = 1'b1;
        dr_we          = 1'b1;
        flag_we        = dec_flag_we;
        state_d        = (dec_mem_rd || dec_mem_wr) ? MEM : WB;
      end

      MEM: begin
        busy          = 1'b1;
        phase[PH_MEM] = 1'b1;
        req           = 1'b1;
        sel_data      = 1'b1;
        we            = dec_mem_wr;
        if (bus.mem_ack) begin
          mdr_we  = dec_mem_rd;
          state_d = WB;
        end
      end

      WB: begin
        busy         = 1'b1;
        phase[PH_WB] = 1'b1;
        rf_we        = dec_reg_we;
        pc_load      = dec_pc_load;
        state_d      = (step_mode || stop_pend) ? IDLE : FETCH;
        stop_pend_d  = 1'b0;
      end

      HALTED: begin
        halted = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Remember a stop seen mid-instruction; WB consumes it at the boundary
    if (stop && busy && state != WB) begin
      stop_pend_d = 1'b1;
    end
  end

`ifdef CORE_SEQ_ICOUNT_EN
  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
    end else if (state == WB) begin
      instr_cnt <= instr_cnt + ICNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed, table-driven bench for core_sequencer.
// Each table row is one clock cycle: inputs applied after the falling edge,
// combinational outputs compared 1 time unit later, then the rising edge
// advances the sequencer. Hand-written sequences cover asynchronous reset.
// Build option: CORE_SEQ_ICOUNT_EN also checks instr_cnt on every row.
module tb_core_sequencer;
  import core_pkg::*;

  localparam int unsigned IN_W  = 10;
  localparam int unsigned EXP_W = 17;
  localparam int unsigned NV    = 33;

  // Input bit positions
  localparam logic [IN_W-1:0] I_START = 10'h200;
  localparam logic [IN_W-1:0] I_STEP  = 10'h100;
  localparam logic [IN_W-1:0] I_STOP  = 10'h080;
  localparam logic [IN_W-1:0] I_HALT  = 10'h040;
  localparam logic [IN_W-1:0] I_MRD   = 10'h020;
  localparam logic [IN_W-1:0] I_MWR   = 10'h010;
  localparam logic [IN_W-1:0] I_RWE   = 10'h008;
  localparam logic [IN_W-1:0] I_FWE   = 10'h004;
  localparam logic [IN_W-1:0] I_PCL   = 10'h002;
  localparam logic [IN_W-1:0] I_ACK   = 10'h001;
  localparam logic [IN_W-1:0] I_NONE  = 10'h000;

  // Expected output bit positions
  localparam logic [EXP_W-1:0] E_REQ = 17'h10000;
  localparam logic [EXP_W-1:0] E_WE  = 17'h08000;
  localparam logic [EXP_W-1:0] E_SEL = 17'h04000;
  localparam logic [EXP_W-1:0] E_IRW = 17'h02000;
  localparam logic [EXP_W-1:0] E_PCI = 17'h01000;
  localparam logic [EXP_W-1:0] E_DRW = 17'h00800;
  localparam logic [EXP_W-1:0] E_MDR = 17'h00400;
  localparam logic [EXP_W-1:0] E_FLG = 17'h00200;
  localparam logic [EXP_W-1:0] E_RFW = 17'h00100;
  localparam logic [EXP_W-1:0] E_PCL = 17'h00080;
  // Per-state status: busy (bit 6) / halted (bit 5) plus phase one-hot
  localparam logic [EXP_W-1:0] O_I   = 17'h00000;
  localparam logic [EXP_W-1:0] O_F   = 17'h00041;
  localparam logic [EXP_W-1:0] O_D   = 17'h00042;
  localparam logic [EXP_W-1:0] O_E   = 17'h00044;
  localparam logic [EXP_W-1:0] O_M   = 17'h00048;
  localparam logic [EXP_W-1:0] O_W   = 17'h00050;
  localparam logic [EXP_W-1:0] O_H   = 17'h00020;

  typedef struct {
    logic [IN_W-1:0]   in;
    logic [EXP_W-1:0]  exp;
    logic [ICNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs [NV];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start, step, stop;
  logic dec_halt, dec_mem_rd, dec_mem_wr, dec_reg_we, dec_flag_we, dec_pc_load;
  logic ir_we, pc_inc, dr_we, mdr_we, flag_we, rf_we, pc_load;
  logic [PHASE_W-1:0] phase;
  logic busy, halted;
`ifdef CORE_SEQ_ICOUNT_EN
  logic [ICNT_W-1:0] instr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  core_sequencer_if bus ();

  core_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step        (step),
    .stop        (stop),
    .dec_halt    (dec_halt),
    .dec_mem_rd  (dec_mem_rd),
    .dec_mem_wr  (dec_mem_wr),
    .dec_reg_we  (dec_reg_we),
    .dec_flag_we (dec_flag_we),
    .dec_pc_load (dec_pc_load),
    .bus         (bus),
    .ir_we       (ir_we),
    .pc_inc      (pc_inc),
    .dr_we       (dr_we),
    .mdr_we      (mdr_we),
    .flag_we     (flag_we),
    .rf_we       (rf_we),
    .pc_load     (pc_load),
    .phase       (phase),
    .busy        (busy),
    .halted      (halted)
`ifdef CORE_SEQ_ICOUNT_EN
    ,
    .instr_cnt   (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [IN_W-1:0] in, input logic [EXP_W-1:0] exp,
                              input logic [ICNT_W-1:0] cnt);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [EXP_W-1:0] observed();
    return {bus.mem_req, bus.mem_we, bus.mem_sel_data, ir_we, pc_inc, dr_we, mdr_we,
            flag_we, rf_we, pc_load, busy, halted, phase};
  endfunction

  task automatic drive(input logic [IN_W-1:0] v);
    start       = v[9];
    step        = v[8];
    stop        = v[7];
    dec_halt    = v[6];
    dec_mem_rd  = v[5];
    dec_mem_wr  = v[4];
    dec_reg_we  = v[3];
    dec_flag_we = v[2];
    dec_pc_load = v[1];
    bus.mem_ack = v[0];
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  initial begin
    // step, ADD-like (reg_we, flag_we, pc_load in WB), ack tied high
    vecs[0]  = mk(I_STEP | I_RWE | I_ACK,         O_I,                         16'd0);
    vecs[1]  = mk(I_RWE | I_ACK,                  O_F | E_REQ | E_IRW | E_PCI, 16'd0);
    vecs[2]  = mk(I_RWE | I_ACK,                  O_D,                         16'd0);
    vecs[3]  = mk(I_RWE | I_FWE | I_ACK,          O_E | E_DRW | E_FLG,         16'd0);
    vecs[4]  = mk(I_RWE | I_PCL | I_ACK,          O_W | E_RFW | E_PCL,         16'd0);
    vecs[5]  = mk(I_NONE,                         O_I,                         16'd1);
    // start, load with ack delayed two cycles on each access
    vecs[6]  = mk(I_START,                        O_I,                         16'd1);
    vecs[7]  = mk(I_MRD | I_RWE,                  O_F | E_REQ,                 16'd1);
    vecs[8]  = mk(I_MRD | I_RWE,                  O_F | E_REQ,                 16'd1);
    vecs[9]  = mk(I_MRD | I_RWE | I_ACK,          O_F | E_REQ | E_IRW | E_PCI, 16'd1);
    vecs[10] = mk(I_MRD | I_RWE,                  O_D,                         16'd1);
    vecs[11] = mk(I_MRD | I_RWE,                  O_E | E_DRW,                 16'd1);
    vecs[12] = mk(I_MRD | I_RWE,                  O_M | E_REQ | E_SEL,         16'd1);
    vecs[13] = mk(I_MRD | I_RWE,                  O_M | E_REQ | E_SEL,         16'd1);
    vecs[14] = mk(I_MRD | I_RWE | I_ACK,          O_M | E_REQ | E_SEL | E_MDR, 16'd1);
    vecs[15] = mk(I_MRD | I_RWE,                  O_W | E_RFW,                 16'd1);
    // free-running: store follows immediately
    vecs[16] = mk(I_MWR | I_ACK,                  O_F | E_REQ | E_IRW | E_PCI, 16'd2);
    vecs[17] = mk(I_MWR,                          O_D,                         16'd2);
    vecs[18] = mk(I_MWR,                          O_E | E_DRW,                 16'd2);
    vecs[19] = mk(I_MWR | I_ACK,                  O_M | E_REQ | E_SEL | E_WE,  16'd2);
    vecs[20] = mk(I_MWR,                          O_W,                         16'd2);
    // stop pulsed in EXEC: instruction completes, then IDLE
    vecs[21] = mk(I_RWE | I_ACK,                  O_F | E_REQ | E_IRW | E_PCI, 16'd3);
    vecs[22] = mk(I_RWE,                          O_D,                         16'd3);
    vecs[23] = mk(I_RWE | I_STOP,                 O_E | E_DRW,                 16'd3);
    vecs[24] = mk(I_RWE,                          O_W | E_RFW,                 16'd3);
    vecs[25] = mk(I_START | I_STOP,               O_I,                         16'd4);
    vecs[26] = mk(I_NONE,                         O_I,                         16'd4);
    // halt: no strobes in DECODE, sticky HALTED, count unchanged
    vecs[27] = mk(I_STEP,                         O_I,                         16'd4);
    vecs[28] = mk(I_HALT | I_ACK,                 O_F | E_REQ | E_IRW | E_PCI, 16'd4);
    vecs[29] = mk(I_HALT | I_RWE | I_PCL,         O_D,                         16'd4);
    vecs[30] = mk(I_START | I_RWE | I_ACK,        O_H,                         16'd4);
    vecs[31] = mk(I_STEP,                         O_H,                         16'd4);
    vecs[32] = mk(I_STOP,                         O_H,                         16'd4);

    drive(I_NONE);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 0, 32'(observed()), 32'(O_I));
`ifdef CORE_SEQ_ICOUNT_EN
    check("reset_cnt", 0, 32'(instr_cnt), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].in);
      #1;
      check("vec", i, 32'(observed()), 32'(vecs[i].exp));
`ifdef CORE_SEQ_ICOUNT_EN
      check("vec_cnt", i, 32'(instr_cnt), 32'(vecs[i].cnt));
`endif
      @(negedge clk);
    end

    // Still halted one cycle later; rst is the only way out
    drive(I_START);
    #1;
    check("halt_sticky", 0, 32'(observed()), 32'(O_H));
    rst = 1'b1;
    #1;
    check("rst_from_halt", 0, 32'(observed()), 32'(O_I));
`ifdef CORE_SEQ_ICOUNT_EN
    check("rst_from_halt_cnt", 0, 32'(instr_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(I_START);
    @(negedge clk);

    // Reset mid-FETCH with mem_req high: request drops at once, no ir_we
    drive(I_RWE);
    #1;
    check("fetch_wait", 0, 32'(observed()), 32'(O_F | E_REQ));
    #1;
    rst = 1'b1;
    drive(I_RWE | I_ACK);
    #1;
    check("rst_mid_fetch", 0, 32'(observed()), 32'(O_I));
    @(posedge clk);
    #1;
    check("rst_held", 0, 32'(observed()), 32'(O_I));
    @(negedge clk);
    rst = 1'b0;
    drive(I_ACK);
    #1;
    check("idle_after_rst", 0, 32'(observed()), 32'(O_I));

    // Sequencer runs normally after reset
    @(negedge clk);
    drive(I_STEP);
    @(negedge clk);
    drive(I_ACK);
    #1;
    check("fetch_after_rst", 0, 32'(observed()), 32'(O_F | E_REQ | E_IRW | E_PCI));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
